// File: rtl/conv_pkg.sv
// Shared types and constants for the convolution feed sequencer.
// Feed FSM states, coefficient bank geometry, reset/flush lengths.
package conv_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CRST,
    CSTART,
    COEF,
    GUARD,
    PIXEL,
    FLUSH,
    DONE
  } feed_state_e;

  localparam int COEF_TAPS   = 9;
  localparam int COEF_W      = 8;
  localparam int CRST_CYCLES = 2;

  function automatic int flush_len(input int n);
    return n + 2;
  endfunction

endpackage

// File: rtl/conv_coef_bank.sv
// Coefficient bank: 9 x 8-bit registers, one write port, one read port.
// Ports: clk_i, rst_ni, we_i/addr_i/data_i/lock_i (write), rd_idx_i/rd_data_o.
module conv_coef_bank
  import conv_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              we_i,
  input  logic [3:0]        addr_i,
  input  logic [COEF_W-1:0] data_i,
  input  logic              lock_i,
  input  logic [3:0]        rd_idx_i,
  output logic [COEF_W-1:0] rd_data_o
);

  logic [COEF_W-1:0] mem_q [COEF_TAPS];
  logic              wr_en;

  assign wr_en = we_i && !lock_i &&
                 (addr_i < 4'(COEF_TAPS));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < COEF_TAPS; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en) begin
      mem_q[addr_i] <= data_i;
    end
  end

  assign rd_data_o = (rd_idx_i < 4'(COEF_TAPS)) ?
                     mem_q[rd_idx_i] : '0;

endmodule

// File: rtl/conv_feed_sequencer.sv
// Feeds the convolution filter: reset, 9 coefficients, N*N pixels, N+2 flush beats.
// Ports: clk, rst_n, cfg_we/addr/data, start, pix_valid/data/ready, conv_rst,
// coeff_load, coeff_in, data_load, data_out, busy, done; csum if CONV_FEED_CSUM_EN.
module conv_feed_sequencer
  import conv_pkg::*;
#(
  parameter int N     = 32,
  parameter int PIX_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_we,
  input  logic [3:0]        cfg_addr,
  input  logic [COEF_W-1:0] cfg_data,
  input  logic              start,
  input  logic              pix_valid,
  input  logic [PIX_W-1:0]  pix_data,
  output logic              pix_ready,
  output logic              conv_rst,
  output logic              coeff_load,
  output logic [COEF_W-1:0] coeff_in,
  output logic              data_load,
  output logic [PIX_W-1:0]  data_out,
  output logic              busy,
  output logic              done
`ifdef CONV_FEED_CSUM_EN
  ,
  output logic [15:0]       csum
`endif
);

  localparam int NPIX = N * N;
  localparam int FLEN = flush_len(N);
  localparam int PCW  = $clog2(NPIX + 1);
  localparam int FCW  = $clog2(N + 3);
  // shared counter also indexes 9 taps
  localparam int CCW  = (FCW < 4) ? 4 : FCW;

  feed_state_e       state_q;
  logic [PCW-1:0]    pcnt_q;
  logic [CCW-1:0]    cnt_q;
  logic              pix_ready_q;
  logic              conv_rst_q;
  logic              coeff_load_q;
  logic [COEF_W-1:0] coeff_in_q;
  logic              data_load_q;
  logic [PIX_W-1:0]  data_out_q;
  logic              busy_q;
  logic              done_q;
  logic [COEF_W-1:0] coef_rd;
  logic              bank_lock;

  assign bank_lock = (state_q != IDLE);

  conv_coef_bank u_bank (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .we_i      (cfg_we),
    .addr_i    (cfg_addr),
    .data_i    (cfg_data),
    .lock_i    (bank_lock),
    .rd_idx_i  (cnt_q[3:0]),
    .rd_data_o (coef_rd)
  );

`ifdef CONV_FEED_CSUM_EN
  logic [15:0] csum_q;
  logic [15:0] pix_ext;
  assign pix_ext = 16'(pix_data);
  assign csum    = csum_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      pcnt_q       <= '0;
      cnt_q        <= '0;
      pix_ready_q  <= 1'b0;
      conv_rst_q   <= 1'b0;
      coeff_load_q <= 1'b0;
      coeff_in_q   <= '0;
      data_load_q  <= 1'b0;
      data_out_q   <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
`ifdef CONV_FEED_CSUM_EN
      csum_q       <= '0;
`endif
    end else begin
      data_load_q  <= 1'b0;
      data_out_q   <= '0;
      coeff_load_q <= 1'b0;
      done_q       <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_q    <= CRST;
            busy_q     <= 1'b1;
            conv_rst_q <= 1'b1;
            cnt_q      <= '0;
`ifdef CONV_FEED_CSUM_EN
            csum_q     <= '0;
`endif
          end
        end
        CRST: begin
          if (cnt_q == CCW'(CRST_CYCLES - 1)) begin
            state_q      <= CSTART;
            conv_rst_q   <= 1'b0;
            coeff_load_q <= 1'b1;
            cnt_q        <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        CSTART: begin
          state_q    <= COEF;
          coeff_in_q <= coef_rd;
          cnt_q      <= CCW'(1);
        end
        COEF: begin
          if (cnt_q == CCW'(COEF_TAPS)) begin
            state_q    <= GUARD;
            coeff_in_q <= '0;
            cnt_q      <= '0;
          end else begin
            coeff_in_q <= coef_rd;
            cnt_q      <= cnt_q + 1'b1;
          end
        end
        GUARD: begin
          state_q     <= PIXEL;
          pix_ready_q <= 1'b1;
          pcnt_q      <= '0;
        end
        PIXEL: begin
          // pix_ready_q is held high for the whole state
          if (pix_valid) begin
            data_load_q <= 1'b1;
            data_out_q  <= pix_data;
`ifdef CONV_FEED_CSUM_EN
            csum_q      <= csum_q + pix_ext;
`endif
            if (pcnt_q == PCW'(NPIX - 1)) begin
              pix_ready_q <= 1'b0;
              state_q     <= FLUSH;
              cnt_q       <= '0;
            end else begin
              pcnt_q <= pcnt_q + 1'b1;
            end
          end
        end
        FLUSH: begin
          // first cycle here still shows the last pixel beat
          if (cnt_q == CCW'(FLEN)) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end else begin
            data_load_q <= 1'b1;
            cnt_q       <= cnt_q + 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign pix_ready  = pix_ready_q;
  assign conv_rst   = conv_rst_q;
  assign coeff_load = coeff_load_q;
  assign coeff_in   = coeff_in_q;
  assign data_load  = data_load_q;
  assign data_out   = data_out_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_conv_feed_sequencer.sv
// Directed bench for conv_feed_sequencer with N=4.
// Checks csum too when built with CONV_FEED_CSUM_EN.
module tb_conv_feed_sequencer;

  localparam int N = 4;

  logic       clk;
  logic       rst_n;
  logic       cfg_we;
  logic [3:0] cfg_addr;
  logic [7:0] cfg_data;
  logic       start;
  logic       pix_valid;
  logic [7:0] pix_data;
  logic       pix_ready;
  logic       conv_rst;
  logic       coeff_load;
  logic [7:0] coeff_in;
  logic       data_load;
  logic [7:0] data_out;
  logic       busy;
  logic       done;
`ifdef CONV_FEED_CSUM_EN
  logic [15:0] csum;
`endif

  conv_feed_sequencer #(.N(N), .PIX_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_we     (cfg_we),
    .cfg_addr   (cfg_addr),
    .cfg_data   (cfg_data),
    .start      (start),
    .pix_valid  (pix_valid),
    .pix_data   (pix_data),
    .pix_ready  (pix_ready),
    .conv_rst   (conv_rst),
    .coeff_load (coeff_load),
    .coeff_in   (coeff_in),
    .data_load  (data_load),
    .data_out   (data_out),
    .busy       (busy),
    .done       (done)
`ifdef CONV_FEED_CSUM_EN
    ,
    .csum       (csum)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  logic [7:0] cap   [9];
  logic [7:0] ecoef [9];
  logic [7:0] beat  [64];
  int         bcyc  [64];
  int n_beats, n_crst, n_cload, n_done;
  logic done_busy;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic write_coefs();
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      cfg_we   = 1'b1;
      cfg_addr = 4'(i);
      cfg_data = 8'(8'h10 + i);
      ecoef[i] = 8'(8'h10 + i);
    end
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic run_frame(input int vmode,
                           input int dmode,
                           input bit spam,
                           input bit busy_wr,
                           input bit cfg_same);
    int nxt;
    int cidx;
    int post;
    n_beats = 0; n_crst = 0; n_cload = 0; n_done = 0;
    done_busy = 1'b0;
    nxt = 0; cidx = -1; post = -1;
    for (int i = 0; i < 9; i++) cap[i] = 8'hxx;
    @(negedge clk);
    start = 1'b1;
    if (cfg_same) begin
      cfg_we = 1'b1; cfg_addr = 4'd0; cfg_data = 8'h77;
    end
    @(negedge clk);
    start  = 1'b0;
    cfg_we = 1'b0;
    for (int cyc = 0; cyc < 400 && post != 0; cyc++) begin
      if (conv_rst) n_crst++;
      if (cidx >= 0 && cidx < 9) begin
        cap[cidx] = coeff_in;
        cidx++;
      end
      if (coeff_load) begin
        n_cload++;
        cidx = 0;
      end
      if (data_load) begin
        if (n_beats < 64) begin
          beat[n_beats] = data_out;
          bcyc[n_beats] = cyc;
        end
        n_beats++;
      end
      if (done) begin
        n_done++;
        done_busy = busy;
        post = 3;
      end
      if (post > 0) post--;
      pix_valid = (vmode == 0) ? 1'b1 : (cyc % 2 == 0);
      pix_data  = dmode ? 8'hFF : 8'(nxt + 1);
      if (pix_valid && pix_ready) nxt++;
      start = spam && (pix_ready || done);
      if (busy_wr && cyc == 5) begin
        cfg_we = 1'b1; cfg_addr = 4'd3; cfg_data = 8'hFF;
      end else begin
        cfg_we = 1'b0;
      end
      @(negedge clk);
    end
    pix_valid = 1'b0;
    start     = 1'b0;
    cfg_we    = 1'b0;
  endtask

  task automatic check_frame(input string tag, input int dmode);
    int perr, ferr, cerr;
    logic [7:0] e;
    perr = 0; ferr = 0; cerr = 0;
    for (int i = 0; i < 16; i++) begin
      e = dmode ? 8'hFF : 8'(i + 1);
      if (beat[i] !== e) perr++;
    end
    for (int i = 16; i < 22; i++)
      if (beat[i] !== 8'h00) ferr++;
    for (int i = 0; i < 9; i++)
      if (cap[i] !== ecoef[i]) cerr++;
    chk({tag, ".conv_rst_cycles"}, n_crst, 2);
    chk({tag, ".coeff_load"}, n_cload, 1);
    chk({tag, ".coef_err"}, cerr, 0);
    chk({tag, ".coef0"}, {24'd0, cap[0]}, {24'd0, ecoef[0]});
    chk({tag, ".beats"}, n_beats, 22);
    chk({tag, ".pix_err"}, perr, 0);
    chk({tag, ".flush_err"}, ferr, 0);
    chk({tag, ".flush_span"}, bcyc[21] - bcyc[16], 5);
    chk({tag, ".done"}, n_done, 1);
    chk({tag, ".done_busy"}, done_busy, 1);
    chk({tag, ".idle_busy"}, busy, 0);
  endtask

  int nb;

  initial begin
    rst_n = 1'b0; cfg_we = 1'b0; cfg_addr = '0;
    cfg_data = '0; start = 1'b0;
    pix_valid = 1'b0; pix_data = '0;
    #12;
    chk("rst.busy", busy, 0);
    chk("rst.pix_ready", pix_ready, 0);
    chk("rst.conv_rst", conv_rst, 0);
    chk("rst.coeff_load", coeff_load, 0);
    chk("rst.coeff_in", coeff_in, 0);
    chk("rst.data_load", data_load, 0);
    chk("rst.data_out", data_out, 0);
    chk("rst.done", done, 0);
`ifdef CONV_FEED_CSUM_EN
    chk("rst.csum", csum, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // 1: basic frame
    write_coefs();
    run_frame(0, 0, 0, 0, 0);
    check_frame("f1", 0);
`ifdef CONV_FEED_CSUM_EN
    chk("f1.csum", csum, 16'd136);
`endif

    // 2 + 3: gappy source, write while busy dropped
    run_frame(1, 0, 0, 1, 0);
    check_frame("f2", 0);

    // 3: out-of-range write in IDLE dropped
    @(negedge clk);
    cfg_we = 1'b1; cfg_addr = 4'd12; cfg_data = 8'h55;
    @(negedge clk);
    cfg_we = 1'b0;

    // 4: repeated start during PIXEL and DONE
    run_frame(0, 0, 1, 0, 0);
    check_frame("f3", 0);

    // 5: reset mid-PIXEL after 7 pixels
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    nb = 0;
    for (int c = 0; c < 100 && nb < 7; c++) begin
      if (data_load) nb++;
      if (nb < 7) begin
        pix_valid = 1'b1;
        pix_data  = 8'(nb + 1);
        @(negedge clk);
      end
    end
    chk("r.pixels_before", nb, 7);
    #2 rst_n = 1'b0;
    #1;
    chk("r.busy", busy, 0);
    chk("r.pix_ready", pix_ready, 0);
    chk("r.data_load", data_load, 0);
    chk("r.data_out", data_out, 0);
    chk("r.conv_rst", conv_rst, 0);
    chk("r.done", done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    pix_valid = 1'b0;
    for (int i = 0; i < 9; i++) ecoef[i] = 8'h00;
    run_frame(0, 0, 0, 0, 0);
    check_frame("f4", 0);

    // cfg write with start: new value used; all-FF pixels
    write_coefs();
    ecoef[0] = 8'h77;
    run_frame(0, 1, 0, 0, 1);
    check_frame("f5", 1);
`ifdef CONV_FEED_CSUM_EN
    chk("f5.csum", csum, 16'h0FF0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, fails);
    $finish;
  end

endmodule
